four_way_mux_arbiter: RTL and testbench

Round-robin arbiter that shares one 16-bit four-way mux datapath between four requesters. It drives the mux select and resets the mux output to zero when idle. Each requester holds a valid/ready-style request, and a single downstream consumer drains the arbitrated stream. The arbiter sits between the register/ALU sources and a shared writeback or memory bus, so the four-way mux is sequenced rather than statically decoded.

---
 rtl/four_way_mux_arbiter_pkg.sv | 21 ++
 rtl/four_way_mux_arbiter_rr_pick4.sv | 22 ++
 rtl/four_way_mux_arbiter.sv | 127 ++++++++++++
 tb/tb_four_way_mux_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/four_way_mux_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the four-way mux arbiter.
package four_way_mux_arbiter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int SEL_W     = 2;
    localparam int NREQ      = 4;
    localparam int CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/four_way_mux_arbiter_rr_pick4.sv
// Combinational rotating picker: first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
    import four_way_mux_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Scan from the farthest position back to ptr so the nearest set bit wins last.
    always_comb begin
        found = |req;
        idx   = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                idx = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/four_way_mux_arbiter.sv
// Round-robin arbiter sequencing a shared four-way mux between four requesters.
// Build option: define FOUR_WAY_ARB_FIXED_PRIO_EN for fixed priority (in0 highest) instead of round-robin.
module four_way_mux_arbiter
    import four_way_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [NREQ-1:0]  ack
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             active;
    logic             xfer;
    logic             last_xfer;

`ifdef FOUR_WAY_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [SEL_W-1:0] ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`endif

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Reset blanks the datapath in the same cycle so an abandoned burst never acks.
    assign active    = (state_q == GRANT) && !reset;
    assign out_valid = active && req[sel_q];
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && ((cnt_q + CNT_W'(1)) == HOLD_LIM);
    assign ack       = xfer ? grant_q : '0;
    assign grant     = grant_q;
    assign sel       = sel_q;

    always_comb begin
        out = '0;
        if (active) begin
            case (sel_q)
                2'd0:    out = in0;
                2'd1:    out = in1;
                2'd2:    out = in2;
                default: out = in3;
            endcase
        end
    end

    // NOTE: every next-state signal is defaulted to its current value first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
`ifndef FOUR_WAY_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = onehot4(pick_idx);
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[sel_q] || last_xfer) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
`ifndef FOUR_WAY_ARB_FIXED_PRIO_EN
                    ptr_d   = sel_q + SEL_W'(1);
`endif
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
`ifndef FOUR_WAY_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
`ifndef FOUR_WAY_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_four_way_mux_arbiter.sv
// Self-checking bench: per-cycle reference model feeds an expectation queue; directed checks follow the test plan.
module tb_four_way_mux_arbiter;

    localparam int W        = 16;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [W-1:0] in0, in1, in2, in3;
    logic         out_ready;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [W-1:0] out;
    logic         out_valid;
    logic [3:0]   ack;

    four_way_mux_arbiter #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   grant;
        logic [1:0]   sel;
        logic [W-1:0] out;
        logic         valid;
        logic [3:0]   ack;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: m_gidx = -1 means idle.
    int m_gidx, m_sel, m_ptr, m_cnt;

    logic [3:0] last_ack;
    logic       last_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] in_of(input int i);
        case (i)
            0:       return in0;
            1:       return in1;
            2:       return in2;
            default: return in3;
        endcase
    endfunction

    // One clock cycle: predict outputs, compare mid-cycle, then advance the model at the edge.
    task automatic step();
        exp_t e;
        exp_t o;
        bit   on;
        in0 = W'($urandom);
        in1 = W'($urandom);
        in3 = W'($urandom);
        on      = (m_gidx >= 0) && !reset;
        e.grant = (m_gidx >= 0) ? 4'(1 << m_gidx) : 4'd0;
        e.sel   = 2'(m_sel);
        e.out   = on ? in_of(m_sel) : '0;
        e.valid = on && req[m_sel];
        e.ack   = (e.valid && out_ready) ? 4'(1 << m_sel) : 4'd0;
        exp_q.push_back(e);

        @(negedge clk);
        o = exp_q.pop_front();
        check("grant", 32'(grant), 32'(o.grant));
        check("sel", 32'(sel), 32'(o.sel));
        check("out", 32'(out), 32'(o.out));
        check("out_valid", 32'(out_valid), 32'(o.valid));
        check("ack", 32'(ack), 32'(o.ack));
        check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        last_ack   = ack;
        last_valid = out_valid;

        @(posedge clk);
        if (reset) begin
            m_gidx = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_gidx < 0) begin
            for (int k = 0; k < 4; k++) begin
`ifdef FOUR_WAY_ARB_FIXED_PRIO_EN
                int i = k;
`else
                int i = (m_ptr + k) % 4;
`endif
                if (m_gidx < 0 && req[i]) begin
                    m_gidx = i; m_sel = i; m_cnt = 0;
                end
            end
        end else if (!req[m_sel] || (e.ack != 0 && m_cnt + 1 == MAX_HOLD)) begin
            m_ptr = (m_sel + 1) % 4; m_gidx = -1; m_cnt = 0;
        end else if (e.ack != 0) begin
            m_cnt++;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        int g;
        reset = 1'b1; req = '0; out_ready = 1'b0;
        in0 = '0; in1 = '0; in2 = 16'hBEEF; in3 = '0;
        repeat (2) @(posedge clk);
        #1;
        m_gidx = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;

        // 1: reset held with all requests pending, then grant to 0 one cycle later
        req = 4'b1111;
        do_reset(2);
        check("t1_grant_after_reset", 32'(grant), 32'h0);
        step();
        check("t1_first_grant", 32'(grant), 32'b0001);

        // 2: single requester bursts MAX_HOLD, one bubble, re-granted
        req = 4'b0100; out_ready = 1'b1;
        do_reset(1);
        step();
        check("t2_grant", 32'(grant), 32'b0100);
        check("t2_sel", 32'(sel), 32'd2);
        check("t2_out", 32'(out), 32'hBEEF);
        repeat (MAX_HOLD) begin
            step();
            check("t2_ack", 32'(last_ack), 32'b0100);
        end
        check("t2_bubble", 32'(grant), 32'h0);
        step();
        check("t2_regrant", 32'(grant), 32'b0100);

        // 3: full load rotation
        req = 4'b1111;
        do_reset(1);
        step();
        for (int n = 0; n < 5; n++) begin
`ifdef FOUR_WAY_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = n % 4;
`endif
            check("t3_grant_order", 32'(grant), 32'(1 << g));
            repeat (MAX_HOLD) begin
                step();
                check("t3_ack", 32'(last_ack), 32'(1 << g));
            end
            check("t3_bubble", 32'(grant), 32'h0);
            step();
        end

        // 4: out_ready low stalls the burst without rotation
        req = 4'b0010; out_ready = 1'b0;
        do_reset(1);
        step();
        repeat (10) begin
            step();
            check("t4_stall_ack", 32'(last_ack), 32'h0);
            check("t4_stall_grant", 32'(grant), 32'b0010);
        end
        out_ready = 1'b1;
        repeat (MAX_HOLD) begin
            step();
            check("t4_ack", 32'(last_ack), 32'b0010);
        end
        check("t4_release", 32'(grant), 32'h0);

        // 5: requester 3 withdraws after 2 acks; pointer wraps to 0
        req = 4'b1000;
        do_reset(1);
        step();
        check("t5_grant3", 32'(grant), 32'b1000);
        repeat (2) step();
        req = 4'b0000;
        step();
        check("t5_withdraw_valid", 32'(last_valid), 32'd0);
        check("t5_idle", 32'(grant), 32'h0);
        req = 4'b1001;
        step();
        check("t5_next_grant", 32'(grant), 32'b0001);

        // 6: reset mid-burst abandons the grant with no ack
        req = 4'b0100;
        do_reset(1);
        step();
        repeat (2) step();
        do_reset(1);
        check("t6_reset_ack", 32'(last_ack), 32'h0);
        check("t6_grant_cleared", 32'(grant), 32'h0);
        req = 4'b1111;
        step();
        check("t6_ptr_zero", 32'(grant), 32'b0001);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
